dmem_responder: RTL
===================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter: DATA_W, 32, word width in bits.
REQ-002 Parameter: ADDR_W, 7, word address width; depth = 2**ADDR_W (128 words).
REQ-003 Port: clk  input  1  clock; all state updates on rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port: CEN  input  1  chip enable, active-low.
REQ-006 Port: WEN  input  1  0 = write, 1 = read.
REQ-007 Port: OEN  input  1  output enable, active-low.
REQ-008 Port: A  input  ADDR_W  word address.
REQ-009 Port: D  input  DATA_W  write data.
REQ-010 Port: Q  output  DATA_W  read data.
REQ-011 Port: busy  output  1  high while the post-reset clear sequence runs.
REQ-012 Port: rd_cnt  output  16  completed read count.
REQ-013 Port: wr_cnt  output  16  completed write count.
REQ-014 Port: par_inject  input  1  inverts the stored parity on a write; functional only with DMEM_PARITY_EN.
REQ-015 Port: perr  output  1  sticky parity-error flag.

Function
REQ-016 The FSM SHALL have three states: CLEAR, READY and HOLD. HOLD is unreachable and decodes to CLEAR.
REQ-017 CLEAR SHALL write 0 to address clr_ptr each cycle and increment clr_ptr from 0.
- The wrap of clr_ptr from 2**ADDR_W-1 to 0 SHALL transition to READY.
- The clear therefore takes exactly 128 cycles.
REQ-018 busy SHALL equal 1 in CLEAR and 0 in READY; busy SHALL be registered.
REQ-019 Write: in READY with CEN=0 and WEN=0, mem[A] SHALL be set to D at the rising edge. OEN is ignored for writes.
REQ-020 Read: Q SHALL be a combinational function of mem[A] when CEN=0, WEN=1, OEN=0 and state=READY; otherwise Q=0.
REQ-021 A write and a read of the same address in the same cycle are impossible (WEN is shared). After a write at edge N, Q SHALL show the new data from edge N onward.
REQ-022 While busy=1, all CEN/WEN accesses SHALL be ignored: no array change, no count, Q=0.
REQ-023 rd_cnt SHALL increment on each edge with an accepted read (READY, CEN=0, WEN=1, OEN=0) and saturate at 16'hFFFF.
REQ-024 wr_cnt SHALL increment on each edge with an accepted write and saturate at 16'hFFFF.
REQ-025 X or Z values on A with CEN=1 SHALL NOT affect state.

Reset
REQ-026 rst_n=0 SHALL asynchronously force: state=CLEAR, clr_ptr=0, busy=1, rd_cnt=0, wr_cnt=0, perr=0.
REQ-027 Reset asserted mid-CLEAR or mid-access SHALL restart the full 128-cycle clear after deassertion. No partial write SHALL complete on the edge where rst_n=0.
REQ-028 Array contents SHALL NOT be reset asynchronously; zeroing happens only through CLEAR.

Configuration
REQ-029 Macro DMEM_PARITY_EN.
- Defined: each word SHALL store one extra even-parity bit over D, inverted when par_inject=1.
- Defined: CLEAR SHALL write parity 0.
- Defined: an accepted read whose stored parity mismatches SHALL set perr at that edge; perr stays 1 until reset.
- Undefined: no parity storage, perr tied 0, par_inject ignored.

Structure
REQ-030 Package dmem_pkg SHALL hold DATA_W/ADDR_W defaults, DEPTH, the state enum {CLEAR, READY, HOLD} and the counter width constant.
REQ-031 The array, including the optional parity column, SHALL be a sub-module dmem_array (1 write port, 1 async read port). The FSM and counters SHALL stay in dmem_responder.

Verification
REQ-032 Reset release -> busy=1 for 128 cycles then 0; a read of any address afterwards gives Q=32'h0.
REQ-033 Write A=7'h05, D=32'hDEADBEEF; then read A=7'h05, OEN=0 -> Q=32'hDEADBEEF, wr_cnt=1, rd_cnt=1.
REQ-034 Read with OEN=1, and a write attempted while busy=1 -> Q=0, counters unchanged, array unchanged.
REQ-035 Write A=7'h7F then A=7'h00 -> both addresses read back correctly with no aliasing (boundary addresses).
REQ-036 Assert rst_n=0 at clear cycle 60 -> after release busy=1 for a full 128 cycles and counters=0.
REQ-037 With DMEM_PARITY_EN: write A=7'h10, D=32'h1 with par_inject=1, then read A=7'h10 -> perr=1 after that edge and held until reset; without the macro, perr stays 0.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder slice.
// DMEM_PARITY_EN selects the optional parity column.
package dmem_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 7;
  localparam int DEPTH      = 2 ** ADDR_W_DEF;
  localparam int CNT_W      = 16;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    READY = 2'd1,
    HOLD  = 2'd2
  } state_e;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic             en);
    return (en && (v != '1)) ? v + CNT_W'(1) : v;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-wide storage: one synchronous write port, one asynchronous read port.
// The parity column, when present, is simply the top bit of each word.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int WORD_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [2**ADDR_W];

  // NOTE: the array has no reset; it is zeroed by the CLEAR sequence, which
  // keeps it mappable onto RAM macros.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: post-reset clear FSM, access gating and counters.
// Define DMEM_PARITY_EN to store an even-parity bit per word and flag errors.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              CEN,
  input  logic              WEN,
  input  logic              OEN,
  input  logic [ADDR_W-1:0] A,
  input  logic [DATA_W-1:0] D,
  output logic [DATA_W-1:0] Q,
  output logic              busy,
  output logic [CNT_W-1:0]  rd_cnt,
  output logic [CNT_W-1:0]  wr_cnt,
  input  logic              par_inject,
  output logic              perr
);

`ifdef DMEM_PARITY_EN
  localparam int WORD_W = DATA_W + 1;
`else
  localparam int WORD_W = DATA_W;
  logic unused_par_inject;
  assign unused_par_inject = par_inject;
`endif

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  clr_ptr_q, clr_ptr_d;
  logic               busy_q, busy_d;
  logic [CNT_W-1:0]   rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0]   wr_cnt_q, wr_cnt_d;
  logic               perr_q, perr_d;

  logic               in_ready, rd_acc, wr_acc;
  logic               arr_we;
  logic [ADDR_W-1:0]  arr_waddr;
  logic [WORD_W-1:0]  arr_wdata, arr_rdata;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= CLEAR;
      clr_ptr_q <= '0;
      busy_q    <= 1'b1;
      rd_cnt_q  <= '0;
      wr_cnt_q  <= '0;
      perr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      busy_q    <= busy_d;
      rd_cnt_q  <= rd_cnt_d;
      wr_cnt_q  <= wr_cnt_d;
      perr_q    <= perr_d;
    end
  end

  // HOLD and any illegal encoding behave exactly like CLEAR.
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    case (state_q)
      READY: state_d = READY;
      default: begin
        clr_ptr_d = clr_ptr_q + ADDR_W'(1);
        state_d   = (&clr_ptr_q) ? READY : CLEAR;
      end
    endcase
  end

  // NOTE: every signal gets a default at the top of the block so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    in_ready  = (state_q == READY);
    rd_acc    = in_ready & ~CEN & WEN & ~OEN;
    wr_acc    = in_ready & ~CEN & ~WEN;
    busy_d    = (state_d != READY);
    // Gating with rst_n keeps a reset edge from landing a write in the array.
    arr_we    = rst_n & (~in_ready | wr_acc);
    arr_waddr = in_ready ? A : clr_ptr_q;
    arr_wdata = '0;
    if (in_ready) begin
`ifdef DMEM_PARITY_EN
      arr_wdata = {(^D) ^ par_inject, D};
`else
      arr_wdata = D;
`endif
    end
    Q        = rd_acc ? arr_rdata[DATA_W-1:0] : '0;
    rd_cnt_d = sat_inc(rd_cnt_q, rd_acc);
    wr_cnt_d = sat_inc(wr_cnt_q, wr_acc);
`ifdef DMEM_PARITY_EN
    // A stored word with correct even parity XORs to zero across all bits.
    perr_d   = perr_q | (rd_acc & (^arr_rdata));
`else
    perr_d   = 1'b0;
`endif
  end

  dmem_array #(
    .WORD_W (WORD_W),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .waddr (arr_waddr),
    .wdata (arr_wdata),
    .raddr (A),
    .rdata (arr_rdata)
  );

  assign busy   = busy_q;
  assign rd_cnt = rd_cnt_q;
  assign wr_cnt = wr_cnt_q;
  assign perr   = perr_q;

endmodule
